detect_seq_ctrl: RTL and testbench
==================================

# detect_seq_ctrl

Sequencing controller for the Moore "1101" serial detector. Accepts parallel words over a valid/ready handshake, clears the detector, and shifts each word into it MSB-first, one bit per clock. It counts the detector's match pulses and returns a per-word match count over a second valid/ready handshake. It sits between a word-oriented producer and the existing bit-serial `moore` detector, replacing bench-driven bit streaming with hardware.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word, serialized MSB-first; legal range ≥ 4.
- CNT_WIDTH, 4, width of the match count; the count saturates.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_data  input  DATA_WIDTH  word to scan.
- in_ready  output  1  controller can accept a word.
- out_valid  output  1  result available.
- out_count  output  CNT_WIDTH  number of "1101" detections in the word.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture in_data into the shift register, clear bit_cnt and match count, and go to LOAD.
- LOAD: one cycle.
  - Detector n_rst is held low, which clears detector history.
  - Next state is SHIFT.
- SHIFT: DATA_WIDTH cycles.
  - Detector i is the shift register MSB.
  - At the end of each cycle, shift left by 1 and increment bit_cnt.
  - After bit_cnt reaches DATA_WIDTH-1, go to DRAIN.
- DRAIN: one cycle.
  - Samples the detector response to the last bit.
  - Next state is DONE.
- DONE:
  - out_valid = 1 and out_count is stable.
  - On out_ready, go to IDLE.
- Match counting: increment on a cycle where detector o = 1 and either:
  - state = SHIFT and bit_cnt ≠ 0, or
  - state = DRAIN.

  The count saturates at 2^CNT_WIDTH−1 and never wraps.
- Detections are counted within a word only, because history is cleared in LOAD. A pattern split across two words never counts.
- Detector i is driven to 0 in every state other than SHIFT.

Reset values:
- state = IDLE.
- in_ready = 1, out_valid = 0, out_count = 0, busy = 0.
- Detector n_rst = 0 while rst is high.

Reset mid-operation:
- rst in any state returns to IDLE on that edge.
- The in-flight word and its count are discarded.
- No out_valid is produced for that word.

## Timing
- The acceptance edge is the rising edge where in_valid & in_ready.
- LOAD occupies cycle 1 after the acceptance edge, SHIFT cycles 2..DATA_WIDTH+1, and DRAIN cycle DATA_WIDTH+2.
- out_valid rises DATA_WIDTH+2 edges after acceptance (10 for DATA_WIDTH = 8).
- The minimum word period is DATA_WIDTH+4 cycles: IDLE, LOAD, SHIFT×W, DRAIN, DONE with out_ready already high.
- The detector is Moore: o reflects bit k during the cycle after bit k is sampled. This is why SHIFT bit 0 is excluded from counting and DRAIN is included.
- Detector n_rst comes from a dedicated flop set low on the edge entering LOAD and high on the edge leaving it. It is glitch-free, and its release coincides with the start of SHIFT bit 0.
- Simultaneous out_ready and a new in_valid: the result is taken in DONE, and the new word is accepted in the following IDLE cycle. There is no bypass.
- in_data is sampled only at the acceptance edge. Changes afterward are ignored.

## Structure
- Package `detect_seq_pkg`:
  - state enum typedef `dsc_state_t` (IDLE, LOAD, SHIFT, DRAIN, DONE).
  - default DATA_WIDTH/CNT_WIDTH constants.
- One sub-module: the existing `moore` detector, instantiated inside `detect_seq_ctrl`.
  - clk → clk.
  - n_rst ← the dedicated reset flop, which is also low during rst.
  - i ← shift register MSB gated by state = SHIFT.
  - o → the counter logic.
- The remaining logic is a single FSM with the shift register, bit_cnt of width $clog2(DATA_WIDTH+1), and the saturating counter.

## Test plan
- Power-on: hold rst 2 cycles → in_ready = 1, out_valid = 0, out_count = 0, busy = 0; deassert, then send 8'b00001101 → out_count = 1.
- Single match: send 8'b01101000 → out_valid exactly 10 edges after acceptance with out_count = 1; 8'b11111111 and 8'b10101010 → out_count = 0.
- Overlap: send 8'b11011010 → out_count = 2; send 8'b11011100 → out_count = 1.
- Word isolation: send 8'b00000110 then 8'b10000000 back-to-back → both out_count = 0, with no cross-word detection.
- Back-pressure: hold out_ready low 5 cycles in DONE → out_valid and out_count stable, in_ready = 0, in_valid ignored; release → IDLE next edge.
- Mid-word reset: assert rst during SHIFT bit 4 → next cycle IDLE with all outputs at reset values and no out_valid. A following 8'b01101000 → out_count = 1.

Source files
------------

// File: rtl/detect_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : detect_seq_pkg
//  Description : Shared types and default sizes for the "1101" sequencing
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package detect_seq_pkg;

  // Controller state encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } dsc_state_t;

  // Default word and count widths
  localparam int C_DSC_DATA_WIDTH = 8;
  localparam int C_DSC_CNT_WIDTH  = 4;

endpackage : detect_seq_pkg
`default_nettype wire

// File: rtl/moore.sv
`default_nettype none
// ============================================================================
//  Module      : moore
//  Description : Bit-serial Moore detector for the overlapping pattern "1101".
//                o is high for the cycle after the final '1' is sampled.
//                n_rst is a synchronous active-low history clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore (
  input  logic clk,
  input  logic n_rst,
  input  logic i,
  output logic o
);

  typedef enum logic [2:0] {
    S_0    = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_1101 = 3'd4
  } moore_state_t;

  moore_state_t r_state;
  moore_state_t w_state_nxt;

  // State register with synchronous history clear
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= S_0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: after a match, a trailing '1' leaves suffix "11" pending
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_0:     w_state_nxt = i ? S_1  : S_0;
      S_1:     w_state_nxt = i ? S_11 : S_0;
      S_11:    w_state_nxt = i ? S_11 : S_110;
      S_110:   w_state_nxt = i ? S_1101 : S_0;
      S_1101:  w_state_nxt = i ? S_11 : S_0;
      default: w_state_nxt = S_0;
    endcase
  end

  assign o = (r_state == S_1101);

endmodule : moore
`default_nettype wire

// File: rtl/detect_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : detect_seq_ctrl
//  Description : Accepts a word over valid/ready, clears the "1101" detector,
//                streams the word into it MSB-first and returns a saturating
//                per-word match count over a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module detect_seq_ctrl
  import detect_seq_pkg::*;
#(
  parameter int DATA_WIDTH = C_DSC_DATA_WIDTH,
  parameter int CNT_WIDTH  = C_DSC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  out_count,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]        C_LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = {CNT_WIDTH{1'b1}};

  dsc_state_t            r_state;
  dsc_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_det_nrst;
  logic                  w_det_nrst;
  logic                  w_det_i;
  logic                  w_det_o;
  logic                  w_accept;
  logic                  w_count_en;

  assign w_accept = (r_state == IDLE) && in_valid;

  // Detector output lags its input by one cycle, so SHIFT bit 0 reflects
  // cleared history and the last bit's response appears in DRAIN.
  assign w_count_en = w_det_o &&
                      (((r_state == SHIFT) && (r_bit_cnt != '0)) ||
                       (r_state == DRAIN));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (r_bit_cnt == C_LAST_BIT) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word capture, serialisation and saturating match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_shift   <= in_data;
      r_bit_cnt <= '0;
      r_count   <= '0;
    end else begin
      if (r_state == SHIFT) begin
        r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if (w_count_en && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  // Dedicated detector clear flop: low across LOAD, released into SHIFT bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_det_nrst <= 1'b0;
    end else if (w_accept) begin
      r_det_nrst <= 1'b0;
    end else if (r_state == LOAD) begin
      r_det_nrst <= 1'b1;
    end
  end

  // Hold the detector cleared for the whole time rst is asserted
  assign w_det_nrst = r_det_nrst & ~rst;
  assign w_det_i    = (r_state == SHIFT) ? r_shift[DATA_WIDTH-1] : 1'b0;

  moore u_moore (
    .clk   (clk),
    .n_rst (w_det_nrst),
    .i     (w_det_i),
    .o     (w_det_o)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_count = r_count;

endmodule : detect_seq_ctrl
`default_nettype wire

// File: tb/tb_detect_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_detect_seq_ctrl
//  Description : Directed self-checking bench for detect_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_detect_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_count;
  logic       out_ready;
  logic       busy;

  int n_vec;
  int n_err;

  detect_seq_ctrl #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word in IDLE and let the acceptance edge happen; returns #1 after it
  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Count edges after acceptance until out_valid; bounded
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    lat = out_valid ? lat - 1 : -1;
    // lat counts edges after acceptance: first check happens #1 after edge 0
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("take_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_word(input string tag, input logic [7:0] d, input int exp_cnt);
    int lat;
    accept(d);
    wait_result(lat);
    chk({tag, "_lat"}, lat, 32'd10);
    chk({tag, "_cnt"}, {28'd0, out_count}, exp_cnt);
    take();
  endtask

  initial begin
    int lat;
    int seen;
    logic [3:0] held;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Power-on reset, two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_count", {28'd0, out_count}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    rst = 1'b0;

    run_word("w00001101", 8'b00001101, 1);
    run_word("w01101000", 8'b01101000, 1);
    run_word("w11111111", 8'b11111111, 0);
    run_word("w10101010", 8'b10101010, 0);
    run_word("w11011010", 8'b11011010, 2);
    run_word("w11011100", 8'b11011100, 1);
    run_word("iso_a",     8'b00000110, 0);
    run_word("iso_b",     8'b10000000, 0);

    // Back-pressure: result held while consumer stalls, new word refused
    accept(8'b11011010);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    wait_result(lat);
    chk("bp_lat", lat, 32'd10);
    held = out_count;
    chk("bp_cnt", {28'd0, held}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold",  {28'd0, out_count}, {28'd0, held});
      chk("bp_ready", {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_ready", {31'd0, in_ready},  32'd1);
    chk("bp_rel_busy",  {31'd0, busy},      32'd0);

    // Mid-word reset during SHIFT bit 4 (cycle after the 5th edge post-accept)
    accept(8'b11011010);
    repeat (5) @(posedge clk);
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_count", {28'd0, out_count}, 32'd0);
    chk("mr_busy_rst",  {31'd0, busy},      32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mr_no_valid", seen, 32'd0);
    run_word("mr_after", 8'b01101000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_detect_seq_ctrl
`default_nettype wire
